// File: rtl/logpwr_if.sv
// Stream bundle between the FFT bin source, the log-power converter and the colour-map stage.
// The master drives bins in and takes pixels out; the slave is the converter itself.
interface logpwr_if #(
  parameter int IW = 16
);
  logic                 i_valid;
  logic                 o_ready;
  logic signed [IW-1:0] i_re;
  logic signed [IW-1:0] i_im;
  logic                 i_last;
  logic [7:0]           i_floor;
  logic                 o_valid;
  logic                 i_ready;
  logic [7:0]           o_pixel;
  logic                 o_last;

  modport master (
    output i_valid, i_re, i_im, i_last, i_floor, i_ready,
    input  o_ready, o_valid, o_pixel, o_last
  );

  modport slave (
    input  i_valid, i_re, i_im, i_last, i_floor, i_ready,
    output o_ready, o_valid, o_pixel, o_last
  );
endinterface

// File: rtl/logpwr.sv
// Four-stage log-power converter: |x|^2, piecewise-linear log2, noise-floor subtraction.
// A single advance enable stalls the whole pipe whenever the output pixel is not taken.
module logpwr #(
  parameter int IW = 16
) (
  input logic     i_clk,
  input logic     i_reset,
  logpwr_if.slave bus
);
  localparam int PW = 2 * IW;
  localparam int EW = $clog2(PW);
  localparam int FB = 8 - EW;
  localparam logic [EW-1:0] TOP = EW'(PW - 1);

  logic          ce;
  logic          v1, v2, v3;
  logic          last1, last2, last3;
  logic [PW-1:0] sq_re, sq_im, p2;
  logic [7:0]    l3;
  logic [PW-1:0] re_x, im_x;
  logic [EW-1:0] lod_e;
  logic [PW-1:0] norm;
  logic [7:0]    lod_l;
  logic [7:0]    pix_next;

  assign ce          = !bus.o_valid || bus.i_ready;
  assign bus.o_ready = ce;

  // Sign-extend so the PW-bit product keeps the full square of a negative component.
  assign re_x = {{IW{bus.i_re[IW-1]}}, bus.i_re};
  assign im_x = {{IW{bus.i_im[IW-1]}}, bus.i_im};

  // Shifting the leading one up to the MSB leaves the fraction bits just below it,
  // zero-filled automatically when the leading one sits near bit 0.
  always_comb begin
    lod_e = '0;
    for (int i = 0; i < PW; i++) begin
      if (p2[i]) lod_e = EW'(i);
    end
    norm  = p2 << (TOP - lod_e);
    lod_l = (p2 == '0) ? 8'd0 : {lod_e, norm[PW-2 -: FB]};
  end

  assign pix_next = (l3 > bus.i_floor) ? (l3 - bus.i_floor) : 8'd0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      last1       <= 1'b0;
      last2       <= 1'b0;
      last3       <= 1'b0;
      sq_re       <= '0;
      sq_im       <= '0;
      p2          <= '0;
      l3          <= '0;
      bus.o_valid <= 1'b0;
      bus.o_pixel <= '0;
      bus.o_last  <= 1'b0;
    end else if (ce) begin
      v1          <= bus.i_valid;
      last1       <= bus.i_last;
      sq_re       <= re_x * re_x;
      sq_im       <= im_x * im_x;
      v2          <= v1;
      last2       <= last1;
      p2          <= sq_re + sq_im;
      v3          <= v2;
      last3       <= last2;
      l3          <= lod_l;
      bus.o_valid <= v3;
      // Bubbles leave the last delivered pixel on the bus.
      if (v3) begin
        bus.o_pixel <= pix_next;
        bus.o_last  <= last3;
      end
    end
  end
endmodule

// File: tb/tb_logpwr.sv
// Scoreboard bench for logpwr: expected pixels are queued on acceptance and
// popped when the output handshake completes.
module tb_logpwr;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   floor_v = 0;

  typedef struct {
    logic [7:0] pix;
    logic       last;
    int         cyc;
  } exp_t;
  exp_t q[$];

  logpwr_if #(.IW(16)) bus ();

  logpwr #(.IW(16)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [7:0] model(input int re, input int im, input int fl);
    longint p;
    longint f;
    int     e;
    int     l;
    p = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    if (p == 0) l = 0;
    else begin
      e = 0;
      while ((p >> (e + 1)) != 0) e++;
      if (e >= 3) f = (p >> (e - 3)) & 7;
      else        f = (p << (3 - e)) & 7;
      l = e * 8 + int'(f);
    end
    return (l > fl) ? 8'(l - fl) : 8'd0;
  endfunction

  // One clock: drive inputs at the falling edge, sample just after, then cross the rising edge.
  task automatic drive(input logic rst_v, input logic v, input int re, input int im,
                       input logic lst, input logic rdy, input logic [7:0] exp_pix,
                       output logic acc, output logic got, output logic ov, output logic ordy,
                       output logic [7:0] gpix, output logic glast, output int ocyc);
    rst         = rst_v;
    bus.i_valid = v;
    bus.i_re    = 16'(re);
    bus.i_im    = 16'(im);
    bus.i_last  = lst;
    bus.i_ready = rdy;
    bus.i_floor = 8'(floor_v);
    #1;
    acc = v && bus.o_ready && !rst_v;
    if (acc) q.push_back('{exp_pix, lst, cyc});
    ov    = bus.o_valid;
    ordy  = bus.o_ready;
    got   = bus.o_valid && rdy && !rst_v;
    gpix  = bus.o_pixel;
    glast = bus.o_last;
    ocyc  = cyc;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic acc, got, ov, ordy, glast;
    logic [7:0] gpix;
    int oc;
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 8'd0, acc, got, ov, ordy, gpix, glast, oc);
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 8'd0, acc, got, ov, ordy, gpix, glast, oc);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 8'd0, acc, got, ov, ordy, gpix, glast, oc);
    checks += 4;
    if (ov !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b want 0", ov); end
    if (gpix !== 8'd0)  begin errors++; $display("FAIL reset_pixel: got %0d want 0", gpix); end
    if (glast !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", glast); end
    if (ordy !== 1'b1)  begin errors++; $display("FAIL reset_ready: got %b want 1", ordy); end
  endtask

  task automatic test_directed();
    int tbl[8][4] = '{'{0, 0, 0, 0}, '{1, 0, 0, 0}, '{3, 4, 0, 36}, '{3, 4, 40, 0},
                      '{3, 4, 30, 6}, '{-32768, -32768, 0, 248}, '{32767, 32767, 0, 247},
                      '{-32768, 0, 0, 240}};
    logic acc, got, ov, ordy, glast;
    logic [7:0] gpix;
    int oc;
    exp_t e;
    for (int t = 0; t < 8; t++) begin
      floor_v = tbl[t][2];
      for (int i = 0; i < 7; i++) begin
        drive(1'b0, i == 0, tbl[t][0], tbl[t][1], 1'b0, 1'b1, 8'(tbl[t][3]),
              acc, got, ov, ordy, gpix, glast, oc);
        if (got) begin
          checks++;
          if (q.size() == 0) begin
            errors++; $display("FAIL dir_extra[%0d]: pixel %0d with empty scoreboard", t, gpix);
          end else begin
            e = q.pop_front();
            if (gpix !== e.pix) begin
              errors++; $display("FAIL dir_pixel[%0d]: got %0d want %0d", t, gpix, e.pix);
            end
            checks++;
            if (oc - e.cyc != 4) begin
              errors++; $display("FAIL dir_latency[%0d]: got %0d want 4", t, oc - e.cyc);
            end
          end
        end
      end
      checks++;
      if (q.size() != 0) begin
        errors++; $display("FAIL dir_lost[%0d]: %0d pending want 0", t, q.size());
        q.delete();
      end
    end
    floor_v = 0;
  endtask

  task automatic test_backpressure();
    int re[20], im[20];
    int nxt = 0, nout = 0;
    logic acc, got, ov, ordy, glast, rdy, v;
    logic prev_stall = 1'b0, prev_last = 1'b0;
    logic [7:0] gpix, prev_pix = 8'd0;
    int oc;
    exp_t e;
    floor_v = 25;
    for (int i = 0; i < 20; i++) begin
      re[i] = $urandom_range(65535) - 32768;
      im[i] = $urandom_range(65535) - 32768;
    end
    for (int i = 0; i < 40; i++) begin
      v   = (nxt < 20);
      rdy = !(i >= 8 && i < 13);
      drive(1'b0, v, v ? re[nxt] : 0, v ? im[nxt] : 0, v && nxt == 19, rdy,
            v ? model(re[nxt], im[nxt], floor_v) : 8'd0, acc, got, ov, ordy, gpix, glast, oc);
      if (acc) nxt++;
      checks++;
      if (ordy !== !(ov && !rdy)) begin
        errors++; $display("FAIL bp_ready[%0d]: got %b want %b", i, ordy, !(ov && !rdy));
      end
      if (prev_stall) begin
        checks++;
        if (ov !== 1'b1 || gpix !== prev_pix || glast !== prev_last) begin
          errors++;
          $display("FAIL bp_hold[%0d]: got v=%b pix=%0d last=%b want v=1 pix=%0d last=%b",
                   i, ov, gpix, glast, prev_pix, prev_last);
        end
      end
      prev_stall = ov && !rdy;
      prev_pix   = gpix;
      prev_last  = glast;
      if (got) begin
        nout++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_extra: pixel %0d with empty scoreboard", gpix);
        end else begin
          e = q.pop_front();
          if (gpix !== e.pix || glast !== e.last) begin
            errors++;
            $display("FAIL bp_data[%0d]: got pix=%0d last=%b want pix=%0d last=%b",
                     nout, gpix, glast, e.pix, e.last);
          end
        end
      end
    end
    checks++;
    if (nout != 20 || q.size() != 0) begin
      errors++; $display("FAIL bp_count: got %0d outputs want 20 (%0d pending)", nout, q.size());
      q.delete();
    end
    floor_v = 0;
  endtask

  task automatic test_bubbles();
    int re, im;
    logic acc, got, ov, ordy, glast, v, want_v;
    logic [7:0] gpix;
    int oc;
    exp_t e;
    floor_v = 10;
    for (int i = 0; i < 16; i++) begin
      v  = (i < 10) && (i % 2 == 0);
      re = $urandom_range(4095) - 2048;
      im = $urandom_range(4095) - 2048;
      drive(1'b0, v, re, im, 1'b0, 1'b1, model(re, im, floor_v),
            acc, got, ov, ordy, gpix, glast, oc);
      want_v = (i >= 4) && (i - 4 < 10) && ((i - 4) % 2 == 0);
      checks++;
      if (ov !== want_v) begin
        errors++; $display("FAIL bub_valid[%0d]: got %b want %b", i, ov, want_v);
      end
      if (got) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bub_extra: pixel %0d with empty scoreboard", gpix);
        end else begin
          e = q.pop_front();
          if (gpix !== e.pix) begin
            errors++; $display("FAIL bub_pixel[%0d]: got %0d want %0d", i, gpix, e.pix);
          end
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL bub_lost: %0d pending want 0", q.size());
      q.delete();
    end
    floor_v = 0;
  endtask

  task automatic test_random();
    int re, im;
    logic acc, got, ov, ordy, glast, v, rdy, lst;
    logic [7:0] gpix;
    int oc;
    exp_t e;
    floor_v = 20;
    for (int i = 0; i < 52; i++) begin
      v   = (i < 40) && ($urandom_range(3) != 0);
      rdy = (i >= 40) || ($urandom_range(2) != 0);
      lst = ($urandom_range(3) == 0);
      re  = $urandom_range(65535) - 32768;
      im  = $urandom_range(65535) - 32768;
      drive(1'b0, v, re, im, lst, rdy, model(re, im, floor_v),
            acc, got, ov, ordy, gpix, glast, oc);
      if (got) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_extra: pixel %0d with empty scoreboard", gpix);
        end else begin
          e = q.pop_front();
          if (gpix !== e.pix || glast !== e.last) begin
            errors++;
            $display("FAIL rnd_data[%0d]: got pix=%0d last=%b want pix=%0d last=%b",
                     i, gpix, glast, e.pix, e.last);
          end
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL rnd_lost: %0d pending want 0", q.size());
      q.delete();
    end
    floor_v = 0;
  endtask

  task automatic test_reset_mid();
    logic acc, got, ov, ordy, glast;
    logic [7:0] gpix;
    int oc;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 100 + i, 7, 1'b1, 1'b1, model(100 + i, 7, floor_v),
            acc, got, ov, ordy, gpix, glast, oc);
      if (got) begin
        checks++;
        e = q.pop_front();
        if (gpix !== e.pix) begin
          errors++; $display("FAIL rm_pre[%0d]: got %0d want %0d", i, gpix, e.pix);
        end
      end
    end
    drive(1'b1, 1'b1, 999, 999, 1'b1, 1'b1, 8'd0, acc, got, ov, ordy, gpix, glast, oc);
    checks++;
    if (ov !== 1'b1) begin errors++; $display("FAIL rm_inflight: o_valid got %b want 1", ov); end
    q.delete();
    drive(1'b0, 1'b1, 3, 4, 1'b0, 1'b1, 8'd36, acc, got, ov, ordy, gpix, glast, oc);
    checks += 5;
    if (ov !== 1'b0)    begin errors++; $display("FAIL rm_valid: got %b want 0", ov); end
    if (gpix !== 8'd0)  begin errors++; $display("FAIL rm_pixel: got %0d want 0", gpix); end
    if (glast !== 1'b0) begin errors++; $display("FAIL rm_last: got %b want 0", glast); end
    if (ordy !== 1'b1)  begin errors++; $display("FAIL rm_ready: got %b want 1", ordy); end
    if (acc !== 1'b1)   begin errors++; $display("FAIL rm_accept: got %b want 1", acc); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 8'd0, acc, got, ov, ordy, gpix, glast, oc);
      if (got) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rm_stale: pixel %0d after reset with empty scoreboard", gpix);
        end else begin
          e = q.pop_front();
          if (gpix !== e.pix || oc - e.cyc != 4) begin
            errors++;
            $display("FAIL rm_fresh: got pix=%0d lat=%0d want pix=%0d lat=4",
                     gpix, oc - e.cyc, e.pix);
          end
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL rm_lost: %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_re    = '0;
    bus.i_im    = '0;
    bus.i_last  = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_floor = '0;
    @(negedge clk);
    $display("[TB] starting logpwr checks");
    test_reset();
    test_directed();
    test_backpressure();
    test_bubbles();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
